// File: rtl/spi_seq_pkg.sv
// Shared types and default parameters for the SPI command sequencer.
//   seq_state_t        : sequencer FSM states
//   DEF_*              : default values for the top-level parameters
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write port; ignored when full
//   pop/pop_data   : head entry is always visible on pop_data; pop ignored when empty
//   count       : occupancy, 0..DEPTH
module spi_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Show zero rather than stale storage when nothing is queued.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: queues command words, issues them one at a time to
// an SPI host, and queues the returned words as responses.
//   clk, rst                        : clock, synchronous active-high reset
//   cmd_data/cmd_valid/cmd_ready    : command write handshake
//   rsp_data/rsp_valid/rsp_ready    : response read handshake (FWFT)
//   host_tx_data/host_tx_start      : to SPI host (data held from START to next START)
//   host_tx_done/host_rx_data/host_rx_valid : from SPI host
//   busy        : FSM not in IDLE
//   timeout_err : sticky, set when the host fails to finish in time
//   cmd_level   : command FIFO occupancy
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a queued command and a free response slot
// START | host_tx_start pulse; command already latched into host_tx_data
// WAIT  | waiting for host_tx_done, capturing rx words, timeout running
// GAP   | enforced idle time between transfers
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          cmd_data,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          host_tx_data,
    output logic                           host_tx_start,
    input  logic                           host_tx_done,
    input  logic [DATA_WIDTH-1:0]          host_rx_data,
    input  logic                           host_rx_valid,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]    cmd_level
);

    localparam int LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [LW-1:0]    FULL_LEVEL   = LW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap configured, a finished transfer returns straight to IDLE.
    localparam seq_state_t       AFTER_XFER   = (GAP_CYCLES == 0) ? IDLE : GAP;

    seq_state_t            state;
    seq_state_t            next_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [DATA_WIDTH-1:0] cmd_head;
    logic [LW-1:0]         rsp_level;
    logic                  cmd_push;
    logic                  take_cmd;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic                  set_err;
    logic                  cmd_empty;
    logic                  rsp_full;

    assign cmd_ready     = (cmd_level != FULL_LEVEL);
    assign cmd_push      = cmd_valid && cmd_ready;
    assign cmd_empty     = (cmd_level == '0);
    assign rsp_full      = (rsp_level == FULL_LEVEL);
    assign rsp_valid     = (rsp_level != '0);
    assign rsp_pop       = rsp_valid && rsp_ready;
    assign host_tx_data  = tx_data_q;
    assign host_tx_start = (state == START);
    assign busy          = (state != IDLE);

    spi_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data (cmd_data),
        .pop       (take_cmd),
        .pop_data  (cmd_head),
        .count     (cmd_level)
    );

    spi_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (host_rx_data),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .count     (rsp_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_data_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (take_cmd) begin
                tx_data_q <= cmd_head;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // The command is popped and latched as START is entered so that the
    // data is already on host_tx_data during the host_tx_start pulse.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        take_cmd   = 1'b0;
        rsp_push   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !rsp_full) begin
                    take_cmd   = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                cnt_next   = '0;
                next_state = WAIT;
            end
            WAIT: begin
                if (host_tx_done) begin
                    rsp_push   = host_rx_valid;
                    cnt_next   = '0;
                    next_state = AFTER_XFER;
                end else if (cnt == TIMEOUT_LAST) begin
                    set_err    = 1'b1;
                    cnt_next   = '0;
                    next_state = AFTER_XFER;
                end else begin
                    rsp_push = host_rx_valid;
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] host_tx_data;
    logic          host_tx_start;
    logic          host_tx_done;
    logic [DW-1:0] host_rx_data;
    logic          host_rx_valid;
    logic          busy;
    logic          timeout_err;
    logic [2:0]    cmd_level;

    // host signals: auto responder (a_*) and hand-driven (m_*)
    logic          a_done = 1'b0, a_rv = 1'b0, m_done = 1'b0, m_rv = 1'b0;
    logic [DW-1:0] a_data = '0, m_data = '0;
    assign host_tx_done  = a_done | m_done;
    assign host_rx_valid = a_rv | m_rv;
    assign host_rx_data  = a_rv ? a_data : m_data;

    spi_cmd_sequencer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .host_tx_data(host_tx_data), .host_tx_start(host_tx_start),
        .host_tx_done(host_tx_done), .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
        .busy(busy), .timeout_err(timeout_err), .cmd_level(cmd_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW-1:0] exp_q[$];
    int            start_cyc[$];
    bit            auto_host   = 1'b0;
    bit            host_answer = 1'b1;
    int            host_lat    = 1;
    logic [DW-1:0] host_cap;
    bit            bp_watch = 1'b0;
    bit            saw_full = 1'b0;

    typedef struct {
        logic [DW-1:0] cmd;
        int            lat;
        logic [DW-1:0] rsp;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [DW-1:0] nibrev(input logic [DW-1:0] d);
        return {d[3:0], d[7:4], d[11:8], d[15:12]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait bound expired, got no event, required event", name);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_tx_start"}, 32'(host_tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(host_tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_cmd_level"}, 32'(cmd_level), 32'd0);
    endtask

    // called at a falling edge; returns at the falling edge after acceptance
    task automatic push_cmd(input logic [DW-1:0] d);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) bound_fail("push_cmd");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0 || cmd_level != 0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (t >= limit) bound_fail(name);
    endtask

    task automatic wait_start(input string name);
        int t;
        t = 0;
        while (!host_tx_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) bound_fail(name);
    endtask

    // response scoreboard: compares each word as it is popped
    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got %0h, required no response", rsp_data);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
        if (!rst && bp_watch && cmd_level == 3'd4) begin
            saw_full = 1'b1;
            check("cmd_ready_when_full", 32'(cmd_ready), 32'd0);
        end
    end

    // SPI host model: answers with the nibble-reversed tx word after host_lat cycles
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && host_tx_start) begin
                start_cyc.push_back(cyc);
                if (auto_host && host_answer) begin
                    host_cap = host_tx_data;
                    repeat (host_lat) @(negedge clk);
                    a_done = 1'b1;
                    a_rv   = 1'b1;
                    a_data = nibrev(host_cap);
                    @(negedge clk);
                    a_done = 1'b0;
                    a_rv   = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 1, 16'h4321};
        vecs[1] = '{16'hFFFF, 3, 16'hFFFF};
        vecs[2] = '{16'h0000, 2, 16'h0000};
        vecs[3] = '{16'hBEEF, 7, 16'hFEEB};
        vecs[4] = '{16'h8001, 4, 16'h1008};
        vecs[5] = '{16'hA5C3, 1, 16'h3C5A};

        // reset values
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // single transfer, hand-driven host
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 16'hA5C3;
        exp_q.push_back(16'h3C5A);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("single_start_early", 32'(host_tx_start), 32'd0);
        check("single_level", 32'(cmd_level), 32'd1);
        @(negedge clk);
        check("single_start", 32'(host_tx_start), 32'd1);
        check("single_tx_data", 32'(host_tx_data), 32'hA5C3);
        check("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_start_one_cycle", 32'(host_tx_start), 32'd0);
        check("single_tx_hold", 32'(host_tx_data), 32'hA5C3);
        m_done = 1'b1;
        m_rv   = 1'b1;
        m_data = 16'h3C5A;
        @(negedge clk);
        m_done = 1'b0;
        m_rv   = 1'b0;
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_head", 32'(rsp_data), 32'h3C5A);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_rsp_popped", 32'(rsp_valid), 32'd0);
        check("single_gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_gap_end", 32'(busy), 32'd0);

        // table-driven transfers with the auto host
        auto_host = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host_lat = vecs[i].lat;
            exp_q.push_back(vecs[i].rsp);
            push_cmd(vecs[i].cmd);
            wait_idle("table_idle", 200);
        end
        check("table_no_timeout", 32'(timeout_err), 32'd0);

        // back-to-back: 4 words, start spacing = START + WAIT(lat) + GAP + IDLE
        start_cyc.delete();
        host_lat = 2;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(nibrev(16'hC001 + 16'(i)));
            push_cmd(16'hC001 + 16'(i));
        end
        wait_idle("b2b_idle", 300);
        check("b2b_starts", 32'(start_cyc.size()), 32'd4);
        if (start_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 32'(1 + 2 + GAP + 1));
        end

        // backpressure: response FIFO fills, 5th transfer held back
        start_cyc.delete();
        rsp_ready = 1'b0;
        host_lat  = 1;
        bp_watch  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(nibrev(16'hD000 + 16'(i)));
            push_cmd(16'hD000 + 16'(i));
        end
        repeat (40) @(negedge clk);
        bp_watch = 1'b0;
        check("bp_saw_full", 32'(saw_full), 32'd1);
        check("bp_starts_held", 32'(start_cyc.size()), 32'd4);
        check("bp_cmd_level", 32'(cmd_level), 32'd2);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        wait_idle("bp_drain", 300);
        check("bp_starts_all", 32'(start_cyc.size()), 32'd6);

        // timeout: host silent
        host_answer = 1'b0;
        push_cmd(16'hC0DE);
        wait_start("to_start");
        repeat (8) @(negedge clk);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("to_set", 32'(timeout_err), 32'd1);
        check("to_gap_busy", 32'(busy), 32'd1);
        check("to_no_rsp", 32'(rsp_valid), 32'd0);
        wait_idle("to_idle", 100);
        host_answer = 1'b1;
        host_lat    = 3;
        exp_q.push_back(16'hE1F0);
        push_cmd(16'h0F1E);
        wait_idle("to_next", 100);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // reset in WAIT, then a late done
        auto_host = 1'b0;
        push_cmd(16'h7E57);
        wait_start("rst_start");
        @(negedge clk);
        check("rst_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midrst");
        m_done = 1'b1;
        m_rv   = 1'b1;
        m_data = 16'hDEAD;
        @(negedge clk);
        m_done = 1'b0;
        m_rv   = 1'b0;
        check("late_done_no_rsp", 32'(rsp_valid), 32'd0);
        check("late_done_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("late_done_no_rsp2", 32'(rsp_valid), 32'd0);
        check("late_done_no_start", 32'(host_tx_start), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the SPI word width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the entries per FIFO; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, giving idle clocks between transfers; 0 is legal.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the maximum clocks to wait for host_tx_done.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports cmd_data (input, DATA_WIDTH), cmd_valid (input, 1) and cmd_ready (output, 1): the command word write handshake.
REQ-008 The block SHALL have ports rsp_data (output, DATA_WIDTH), rsp_valid (output, 1) and rsp_ready (input, 1): the response word read handshake.
REQ-009 The block SHALL have ports host_tx_data (output, DATA_WIDTH) and host_tx_start (output, 1), which drive the SPI host.
REQ-010 The block SHALL have ports host_tx_done (input, 1), host_rx_data (input, DATA_WIDTH) and host_rx_valid (input, 1), which are returned by the SPI host.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set on timeout.
REQ-013 The block SHALL have port cmd_level, output, clog2(FIFO_DEPTH)+1 bits: current command FIFO occupancy.

Function
REQ-014 A command SHALL be accepted on the cycle cmd_valid and cmd_ready are both high; cmd_ready SHALL equal "command FIFO not full", with no write-through when full even if a pop occurs in the same cycle.
REQ-015 rsp_valid SHALL equal "response FIFO not empty"; rsp_data SHALL show the head entry first-word-fall-through and SHALL be popped when rsp_valid and rsp_ready are both high.
REQ-016 The FSM SHALL have states IDLE, START, WAIT and GAP.
REQ-017 The FSM SHALL move IDLE->START only when the command FIFO is non-empty and the response FIFO has at least 1 free entry; this guarantees that no rx word is ever dropped.
REQ-018 In START, host_tx_start SHALL be high for exactly 1 cycle, the head command SHALL be popped into a host_tx_data holding register, and the next state SHALL be WAIT.
REQ-019 host_tx_data SHALL be registered and SHALL stay stable from START until the next START.
REQ-020 A command accepted into an empty FIFO while in IDLE SHALL produce host_tx_start exactly 2 cycles after acceptance.
REQ-021 In WAIT, a cycle with host_rx_valid high SHALL push host_rx_data into the response FIFO.
REQ-022 In WAIT, a cycle with host_tx_done high SHALL cause GAP (or IDLE when GAP_CYCLES=0); done and rx_valid arriving in the same cycle SHALL be handled in that single cycle.
REQ-023 The WAIT counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES without host_tx_done, timeout_err SHALL be set, no response SHALL be pushed, and the FSM SHALL go to GAP.
REQ-024 host_rx_valid outside WAIT SHALL be ignored.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-026 Command and response FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL count 0..FIFO_DEPTH.
REQ-027 A push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave its occupancy unchanged.
REQ-028 Pop on empty and push on full SHALL never occur.

Reset
REQ-029 On rst high at a clock edge, the state SHALL go to IDLE and both FIFOs SHALL be emptied.
REQ-030 Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, host_tx_start=0, host_tx_data=0, busy=0, timeout_err=0, cmd_level=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer; a host_tx_done arriving after reset is released SHALL be ignored, because the state is IDLE.
REQ-032 timeout_err SHALL clear only on reset.

Structure
REQ-033 Package spi_seq_pkg SHALL hold the FSM state enum (IDLE, START, WAIT, GAP) and the default DATA_WIDTH, FIFO_DEPTH, GAP_CYCLES and TIMEOUT_CYCLES constants.
REQ-034 A sub-module spi_seq_fifo (synchronous FWFT FIFO, parameterised width and depth, with count output) SHALL be instantiated twice, once for commands and once for responses.
REQ-035 The FSM, the gap/timeout counter and the tx holding register SHALL live in the top level.

Verification
REQ-036 Single transfer: push 16'hA5C3 while IDLE -> host_tx_start exactly 2 cycles later with host_tx_data=16'hA5C3; host returns done+rx_valid with 16'h3C5A -> rsp_valid high next cycle, rsp_data=16'h3C5A.
REQ-037 Back-to-back: push 4 words with GAP_CYCLES=2 -> 4 host_tx_start pulses, each separated by done + 2 gap cycles; responses pop in order.
REQ-038 Full/backpressure: hold rsp_ready=0 and push 6 words -> cmd_ready low when cmd_level=4; after 4 responses, no 5th host_tx_start until rsp_ready pops one.
REQ-039 Timeout: TIMEOUT_CYCLES=8, host never answers -> timeout_err high 8 cycles after entering WAIT, no response pushed, next command still issued.
REQ-040 Reset mid-WAIT: assert rst 1 cycle -> all outputs at reset values next cycle; a late host_tx_done produces no response.
